// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared FSM encoding and default widths for the fetch stage,
// control unit and instruction memory.
package fetch_sequencer_pkg;
   typedef enum logic [1:0] {
      RUN        = 2'd0,
      WAIT_PRESS = 2'd1,
      HALTED     = 2'd2
   } fetchState_t;
   localparam int unsigned DEF_ADDR_WIDTH  = 10;
   localparam int unsigned DEF_TIMER_WIDTH = 16;
   localparam int unsigned DEF_IRQ_VECTOR  = 1;
endpackage

// File: rtl/fetch_sequencer_button_sync_edge.sv
// button_sync_edge: 2-flop synchroniser for the raw confirm button plus a
// previous-value flop; rise pulses for one cycle per synchronised 0->1 transition.
module button_sync_edge (
   input  logic clock,
   input  logic resetn,
   input  logic button,
   output logic rise
);
   logic syncMeta, syncOut, prevOut;
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         syncMeta <= 1'b0;
         syncOut  <= 1'b0;
         prevOut  <= 1'b0;
      end else begin
         syncMeta <= button;
         syncOut  <= syncMeta;
         prevOut  <= syncOut;
      end
   end
   assign rise = syncOut & ~prevOut;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register and next-PC selection, input-wait handshake,
// preemption timer, interrupt flag and saved-PC buffer.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned TIMER_WIDTH = DEF_TIMER_WIDTH,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned IRQ_VECTOR  = DEF_IRQ_VECTOR
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   halt,
   input  logic                   pc_funct,
   input  logic                   beq,
   input  logic                   bne,
   input  logic                   zero,
   input  logic [ADDR_WIDTH-1:0]  branch_imm,
   input  logic                   control_jump,
   input  logic [ADDR_WIDTH-1:0]  jump_addr,
   input  logic                   jump_reg,
   input  logic [ADDR_WIDTH-1:0]  reg_target,
   input  logic                   in_req,
   input  logic                   button,
   input  logic                   set_clock,
   input  logic [TIMER_WIDTH-1:0] set_value,
   input  logic                   get_interruption,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic [ADDR_WIDTH-1:0]  pc_plus1,
   output logic [ADDR_WIDTH-1:0]  pc_buffer,
   output logic                   irq_flag,
   output logic                   waiting,
   output logic                   input_commit,
   output logic                   halted
);
   fetchState_t state;
   logic [TIMER_WIDTH-1:0] timer;
   logic [ADDR_WIDTH-1:0] nextPc;
   logic buttonRise, branchTaken, counting, expire;
   button_sync_edge uSync (
      .clock  (clock),
      .resetn (resetn),
      .button (button),
      .rise   (buttonRise)
   );
   assign pc_plus1    = pc + 1'b1;
   assign branchTaken = (beq & zero) | (bne & ~zero);
   assign counting    = (state == RUN) & ~halt & ~in_req;
   // A same-cycle load overrides the 1->0 step, so no interrupt is taken.
   assign expire      = counting & (timer == TIMER_WIDTH'(1)) & ~set_clock;
   assign waiting     = state == WAIT_PRESS;
   assign halted      = state == HALTED;
   always_comb
      nextPc = jump_reg ? reg_target : control_jump ? jump_addr :
               branchTaken ? pc_plus1 + branch_imm : pc_funct ? pc_plus1 : pc;
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= RUN;
         pc           <= ADDR_WIDTH'(RESET_PC);
         pc_buffer    <= '0;
         irq_flag     <= 1'b0;
         input_commit <= 1'b0;
         timer        <= '0;
      end else begin
         case (state)
            RUN: begin
               timer    <= set_clock ? set_value : (counting && timer != '0) ? timer - 1'b1 : timer;
               irq_flag <= expire | (irq_flag & ~get_interruption);
               if (expire) pc_buffer <= nextPc;
               if (halt) state <= HALTED;
               else if (in_req) state <= WAIT_PRESS;
               else pc <= expire ? ADDR_WIDTH'(IRQ_VECTOR) : nextPc;
            end
            WAIT_PRESS: begin
               if (input_commit) begin
                  pc           <= pc_plus1;
                  state        <= RUN;
                  input_commit <= 1'b0;
               end else begin
                  input_commit <= buttonRise;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plus random stimulus; a behavioural model pushes the
// expected post-edge outputs into a scoreboard that a separate monitor drains.
module tb_fetch_sequencer;
   logic clock = 1'b0, resetn = 1'b0;
   logic halt = 0, pc_funct = 0, beq = 0, bne = 0, zero = 0, control_jump = 0, jump_reg = 0;
   logic in_req = 0, button = 0, set_clock = 0, get_interruption = 0;
   logic [9:0] branch_imm = '0, jump_addr = '0, reg_target = '0;
   logic [15:0] set_value = '0;
   logic [9:0] pc, pc_plus1, pc_buffer;
   logic irq_flag, waiting, input_commit, halted;

   always #5 clock = ~clock;

   fetch_sequencer dut (
      .clock(clock), .resetn(resetn), .halt(halt), .pc_funct(pc_funct), .beq(beq), .bne(bne),
      .zero(zero), .branch_imm(branch_imm), .control_jump(control_jump), .jump_addr(jump_addr),
      .jump_reg(jump_reg), .reg_target(reg_target), .in_req(in_req), .button(button),
      .set_clock(set_clock), .set_value(set_value), .get_interruption(get_interruption),
      .pc(pc), .pc_plus1(pc_plus1), .pc_buffer(pc_buffer), .irq_flag(irq_flag),
      .waiting(waiting), .input_commit(input_commit), .halted(halted)
   );

   typedef struct {
      int pcV, bufV;
      bit irq, wt, cm, hl;
   } exp_t;
   exp_t sb[$];
   int checks = 0, fails = 0;

   // Reference model: mode 0 = running, 1 = waiting for input, 2 = halted.
   int mPc, mBuf, mTimer, mMode;
   bit mIrq, mCommit;
   bit btnHist[3];

   task automatic check(string name, int act, int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic pushExp();
      exp_t e;
      e.pcV = mPc; e.bufV = mBuf; e.irq = mIrq; e.wt = (mMode == 1); e.cm = mCommit; e.hl = (mMode == 2);
      sb.push_back(e);
   endtask

   task automatic modelReset();
      mPc = 0; mBuf = 0; mTimer = 0; mMode = 0; mIrq = 0; mCommit = 0;
      btnHist = '{0, 0, 0};
   endtask

   task automatic modelStep();
      bit rise, cnt, exp;
      int nat, off;
      // The synchronised button seen two samples ago rose relative to three ago.
      rise = btnHist[1] && !btnHist[2];
      if (mMode == 1) begin
         if (mCommit) begin
            mPc = (mPc + 1) % 1024; mMode = 0; mCommit = 0;
         end else mCommit = rise;
      end else if (mMode == 0) begin
         cnt = !halt && !in_req;
         exp = cnt && mTimer == 1 && !set_clock;
         off = int'($signed(branch_imm));
         if (jump_reg) nat = int'(reg_target);
         else if (control_jump) nat = int'(jump_addr);
         else if ((beq && zero) || (bne && !zero)) nat = ((mPc + 1 + off) % 1024 + 1024) % 1024;
         else if (pc_funct) nat = (mPc + 1) % 1024;
         else nat = mPc;
         if (set_clock) mTimer = int'(set_value);
         else if (cnt && mTimer > 0) mTimer = mTimer - 1;
         if (exp) begin mBuf = nat; mIrq = 1; end
         else if (get_interruption) mIrq = 0;
         if (halt) mMode = 2;
         else if (in_req) mMode = 1;
         else mPc = exp ? 1 : nat;
      end
      btnHist[2] = btnHist[1]; btnHist[1] = btnHist[0]; btnHist[0] = button;
   endtask

   task automatic tick();
      modelStep();
      pushExp();
      @(negedge clock);
   endtask

   task automatic setIdle();
      halt = 0; pc_funct = 0; beq = 0; bne = 0; zero = 0; branch_imm = '0; control_jump = 0;
      jump_addr = '0; jump_reg = 0; reg_target = '0; in_req = 0; set_clock = 0; set_value = '0;
      get_interruption = 0;
   endtask

   task automatic doReset();
      resetn = 0;
      #1;
      check("async_reset_pc", int'(pc), 0);
      check("async_reset_irq", int'(irq_flag), 0);
      modelReset();
      pushExp();
      @(negedge clock);
      resetn = 1;
   endtask

   task automatic jumpTo(input int a);
      setIdle(); control_jump = 1; jump_addr = 10'(a); tick(); setIdle();
   endtask

   task automatic randomTick(input bit allowReset);
      halt = 0;
      pc_funct = $urandom_range(0, 3) != 0;
      beq = $urandom_range(0, 7) == 0;
      bne = $urandom_range(0, 7) == 0;
      zero = 1'($urandom);
      branch_imm = 10'($urandom);
      control_jump = $urandom_range(0, 9) == 0;
      jump_addr = 10'($urandom);
      jump_reg = $urandom_range(0, 11) == 0;
      reg_target = 10'($urandom);
      in_req = $urandom_range(0, 19) == 0;
      set_clock = $urandom_range(0, 9) == 0;
      set_value = 16'($urandom_range(0, 12));
      get_interruption = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 3) == 0) button = ~button;
      if (allowReset && $urandom_range(0, 99) == 0) doReset();
      else tick();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc", int'(pc), e.pcV);
            check("pc_plus1", int'(pc_plus1), (e.pcV + 1) % 1024);
            check("pc_buffer", int'(pc_buffer), e.bufV);
            check("irq_flag", int'(irq_flag), int'(e.irq));
            check("waiting", int'(waiting), int'(e.wt));
            check("input_commit", int'(input_commit), int'(e.cm));
            check("halted", int'(halted), int'(e.hl));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : driver
      int commits;
      modelReset();
      @(negedge clock);
      doReset();
      setIdle(); pc_funct = 1;
      repeat (3) tick();
      check("advance_pc3", int'(pc), 3);
      doReset();
      jumpTo(5);
      beq = 1; zero = 1; branch_imm = 10'h3FD; tick(); setIdle();
      check("beq_taken", int'(pc), 3);
      jumpTo(5);
      bne = 1; zero = 1; pc_funct = 1; tick(); setIdle();
      check("bne_not_taken", int'(pc), 6);
      jumpTo(1023);
      pc_funct = 1; tick(); setIdle();
      check("pc_wrap", int'(pc), 0);
      button = 1;
      jumpTo(8);
      repeat (3) tick();
      commits = 0;
      in_req = 1; tick(); setIdle();
      repeat (5) begin tick(); commits += int'(input_commit); end
      check("wait_hold_pc", int'(pc), 8);
      check("wait_flag", int'(waiting), 1);
      button = 0;
      repeat (3) begin tick(); commits += int'(input_commit); end
      button = 1;
      repeat (8) begin tick(); commits += int'(input_commit); end
      check("commit_pulses", commits, 1);
      check("wait_exit_pc", int'(pc), 9);
      check("wait_exit_flag", int'(waiting), 0);
      button = 0;
      jumpTo(10);
      set_clock = 1; set_value = 16'd3; tick(); setIdle();
      pc_funct = 1; repeat (3) tick(); setIdle();
      check("irq_vector_pc", int'(pc), 1);
      check("irq_saved_pc", int'(pc_buffer), 13);
      check("irq_set", int'(irq_flag), 1);
      get_interruption = 1; tick(); setIdle();
      check("irq_cleared", int'(irq_flag), 0);
      set_clock = 1; set_value = 16'd1; tick(); setIdle();
      pc_funct = 1; set_clock = 1; set_value = 16'd5; tick(); set_clock = 0;
      check("load_beats_expiry", int'(irq_flag), 0);
      repeat (4) tick();
      check("reload_not_yet", int'(irq_flag), 0);
      tick(); setIdle();
      check("reload_expired", int'(irq_flag), 1);
      get_interruption = 1; tick(); setIdle();
      set_clock = 1; set_value = 16'd1; tick(); setIdle();
      pc_funct = 1; get_interruption = 1; tick(); setIdle();
      check("set_beats_clear", int'(irq_flag), 1);
      set_clock = 1; set_value = 16'd3; tick(); setIdle();
      pc_funct = 1; tick();
      doReset();
      pc_funct = 1; repeat (5) tick(); setIdle();
      check("no_irq_after_reset", int'(irq_flag), 0);
      repeat (400) randomTick(1);
      doReset();
      button = 0;
      jumpTo(20);
      halt = 1; tick(); setIdle();
      check("halted_flag", int'(halted), 1);
      repeat (50) randomTick(0);
      check("halted_pc", int'(pc), 20);
      setIdle();
      doReset();
      check("reset_after_halt", int'(pc), 0);
      tick();
      @(posedge clock);
      #2;
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
